// File: rtl/cheri_dmem_responder_if.sv
// Tagged 33-bit data bus (req/gnt/rvalid) between the core's data port and a memory responder.
// Bit 32 of the data fields carries the capability tag.
interface cheri_dmem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic        data_is_cap_i;
  logic [32:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [32:0] data_rdata_o;
  logic        data_err_o;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_is_cap_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_is_cap_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/cheri_dmem_responder.sv
// Data-memory responder for the tagged data bus: word array plus per-word capability tag,
// tag clearing on non-capability stores, responses after a fixed latency.
module cheri_dmem_responder #(
  parameter logic [31:0] BaseAddr    = 32'h2000_0000,
  parameter int unsigned Depth       = 1024,
  parameter int unsigned RespLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  cheri_dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(Depth);

  logic          gnt;
  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic          below_base;
  logic          out_of_range;
  logic          misaligned;
  logic          bad_cap_store;
  logic          req_err;
  logic          wr_en;
  logic [31:0]   rd_word;

  logic [Depth-1:0] tag_reg;
  logic             s0_valid_reg;
  logic             s0_err_reg;
  logic             s0_load_reg;
  logic             s0_cap_reg;
  logic             s0_tag_reg;
  logic [32:0]      s0_rdata;
  logic             s0_err;

  assign gnt            = bus.data_req_i & ~stall_i & ~rst_i;
  assign bus.data_gnt_o = gnt;

  // Word offset is taken on addr[31:2] so misalignment is judged on the raw address bits.
  assign word_off      = bus.data_addr_i[31:2] - BaseAddr[31:2];
  assign idx           = word_off[AW-1:0];
  assign below_base    = bus.data_addr_i < BaseAddr;
  assign out_of_range  = |word_off[29:AW];
  assign misaligned    = |bus.data_addr_i[1:0];
  assign bad_cap_store = bus.data_we_i & bus.data_is_cap_i & (bus.data_be_i != 4'hF);
  assign req_err       = misaligned | below_base | out_of_range | bad_cap_store;
  assign wr_en         = gnt & bus.data_we_i & ~req_err;

  // One byte-wide RAM per lane keeps byte-enable writes inferable as block RAM.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_b [Depth];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk_i) begin
        if (wr_en && bus.data_be_i[gi]) begin
          mem_b[idx] <= bus.data_wdata_i[8*gi +: 8];
        end
        if (gnt) begin
          rd_byte_reg <= mem_b[idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_reg <= '0;
    end else if (wr_en) begin
      tag_reg[idx] <= bus.data_is_cap_i & bus.data_wdata_i[32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid_reg <= 1'b0;
      s0_err_reg   <= 1'b0;
      s0_load_reg  <= 1'b0;
      s0_cap_reg   <= 1'b0;
      s0_tag_reg   <= 1'b0;
    end else begin
      s0_valid_reg <= gnt;
      if (gnt) begin
        s0_err_reg  <= req_err;
        s0_load_reg <= ~bus.data_we_i;
        s0_cap_reg  <= bus.data_is_cap_i;
        s0_tag_reg  <= tag_reg[idx];
      end
    end
  end

  // Gate the raw RAM word so stores, errors and idle cycles present all-zero data.
  assign s0_rdata = (s0_valid_reg & ~s0_err_reg & s0_load_reg)
                  ? {s0_cap_reg & s0_tag_reg, rd_word} : 33'h0;
  assign s0_err   = s0_valid_reg & s0_err_reg;

  generate
    if (RespLatency == 1) begin : g_direct
      assign bus.data_rvalid_o = s0_valid_reg;
      assign bus.data_err_o    = s0_err;
      assign bus.data_rdata_o  = s0_rdata;
    end else begin : g_tail
      logic        tail_valid_reg [RespLatency-1];
      logic        tail_err_reg   [RespLatency-1];
      logic [32:0] tail_data_reg  [RespLatency-1];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < int'(RespLatency) - 1; i++) begin
            tail_valid_reg[i] <= 1'b0;
            tail_err_reg[i]   <= 1'b0;
            tail_data_reg[i]  <= 33'h0;
          end
        end else begin
          tail_valid_reg[0] <= s0_valid_reg;
          tail_err_reg[0]   <= s0_err;
          tail_data_reg[0]  <= s0_rdata;
          for (int i = 1; i < int'(RespLatency) - 1; i++) begin
            tail_valid_reg[i] <= tail_valid_reg[i-1];
            tail_err_reg[i]   <= tail_err_reg[i-1];
            tail_data_reg[i]  <= tail_data_reg[i-1];
          end
        end
      end

      assign bus.data_rvalid_o = tail_valid_reg[RespLatency-2];
      assign bus.data_err_o    = tail_err_reg[RespLatency-2];
      assign bus.data_rdata_o  = tail_data_reg[RespLatency-2];
    end
  endgenerate

endmodule

// File: doc/cheri_dmem_responder.md
# cheri_dmem_responder

Behavioural/synthesisable data-memory responder: the memory end of the core's 33-bit tagged data bus (req/gnt/rvalid). It backs a word array with a per-word capability tag bit, enforces the tag-clearing rules for non-capability stores, and returns responses after a fixed, parameterised latency. It is used in the top-level simulation harness and FPGA builds as the slave behind the core's data port, with a stall input so benches can exercise grant back-pressure.

## Interface
Parameters:
- BaseAddr, 32'h2000_0000: byte address of word 0.
- Depth, 1024: number of 33-bit words; power of two, ≥ 4.
- RespLatency, 1: cycles from grant to rvalid; range 1..8.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- stall_i  in  1  when 1, suppresses grant this cycle.
- data_req_i  in  1  request valid; held until granted.
- data_gnt_o  out  1  request accepted this cycle.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address, word aligned.
- data_is_cap_i  in  1  access is one capability half, tag significant.
- data_wdata_i  in  33  store data; bit 32 = tag.
- data_rvalid_o  out  1  response valid, single-cycle pulse.
- data_rdata_o  out  33  load data; bit 32 = tag.
- data_err_o  out  1  response is a bus error; qualified by rvalid.

## Operation
- Grant: data_gnt_o = data_req_i & ~stall_i & ~rst_i (combinational). At most one grant per cycle; no outstanding limit beyond pipeline depth (RespLatency entries, always sufficient).
- Decode at grant: idx = (addr − BaseAddr) >> 2. Error if addr[1:0] ≠ 0, addr < BaseAddr, idx ≥ Depth, or (we & is_cap & be ≠ 4'hF). Error accesses do not modify the array.
- Store, is_cap=1, no error: mem[idx] ← wdata[32:0] (tag written from wdata[32]).
- Store, is_cap=0, no error: bytes with be[i]=1 updated from wdata[8i+7:8i]; tag[idx] ← 0 regardless of be (be = 0 still clears tag).
- Load, no error: data = mem[idx][31:0]; tag = is_cap ? tag[idx] : 0. Sampled at grant edge, after any same-edge write is excluded (a load granted in the same cycle as nothing else; sequential requests see prior writes).
- Response pipeline: shift register of RespLatency stages holding {valid, err, rdata}. Stores respond with rdata = 0. Error responses: rdata = 0, err = 1.
- Memory data bits not reset; tag bits all cleared by reset.

## Timing
- Request granted in cycle N (gnt=1 sampled at edge N) → data_rvalid_o = 1 in cycle N+RespLatency, for exactly one cycle; responses in grant order.
- Back-to-back grants every cycle produce back-to-back rvalid every cycle.
- Load granted in cycle N+1 after store granted in cycle N to the same word returns the stored value.
- stall_i held: gnt stays 0; req/attributes must stay stable (requestor rule); pipeline continues draining.
- Reset values (cycle after rst_i=1): data_rvalid_o=0, data_rdata_o=0, data_err_o=0, all pipeline stages invalid, all tags 0; data_gnt_o=0 during reset.
- Reset mid-operation: in-flight responses are discarded (never issued); a store granted in the reset cycle is not performed.
- data_rdata_o/data_err_o are 0 whenever data_rvalid_o=0.

## Test plan
- Store 33'h0_DEAD_BEEF, is_cap=0, be=F to BaseAddr+4, then load is_cap=0 → rvalid 1 cycle after grant (RespLatency=1), rdata=33'h0_DEAD_BEEF, err=0.
- Store 33'h1_1234_5678 is_cap=1 to BaseAddr+8; load is_cap=1 → rdata=33'h1_1234_5678; then store be=4'b0001 wdata 0xAB is_cap=0; load is_cap=1 → 33'h0_1234_56AB.
- Load is_cap=0 from tagged word → rdata[32]=0; load from BaseAddr+4*Depth and BaseAddr+2 → err=1, rdata=0; cap store with be=4'h3 → err=1, word unchanged.
- RespLatency=3, 4 back-to-back loads granted cycles 10–13 → rvalid cycles 13–16, data in order.
- stall_i=1 for cycles 5–7 with req held from cycle 5 → gnt first 1 in cycle 8, rvalid in cycle 8+RespLatency.
- RespLatency=3, grants in cycles 10, 11; rst_i=1 in cycle 12 → no rvalid in cycles 13–14, all tags read back 0 via is_cap loads.
